// File: rtl/serdes_pkg.sv
// Shared types and constants for the receive deserializer.
// Provides the alignment FSM state encoding and the default sync word.
package serdes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        LOCKED
    } deser_state_t;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hBC;

endpackage

// File: rtl/deser_shift_reg.sv
// Serial-in / parallel-out shift register for the deserializer.
// Ports: clk_i, rst_i (sync, active-high), clr_i (sync clear), en_i (shift),
//        ser_i (serial bit), q_o (current contents), nxt_o (contents after a shift).
module deser_shift_reg
    import serdes_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] nxt_o
);

    logic [WIDTH-1:0] sr_q;

    // nxt_o lets the parent compare the post-shift value in the same cycle.
    generate
        if (MSB_FIRST) begin : g_msb
            assign nxt_o = {sr_q[WIDTH-2:0], ser_i};
        end else begin : g_lsb
            assign nxt_o = {ser_i, sr_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            sr_q <= '0;
        end else if (en_i) begin
            sr_q <= nxt_o;
        end
    end

    assign q_o = sr_q;

endmodule

// File: rtl/serdes_deser.sv
// Receive deserializer: hunts for a sync word, then assembles WIDTH-bit
// words and offers them through a 1-entry valid/ready holding register.
// Ports: clk_i, rst_i (sync, active-high), ser_i/ser_vld_i (serial input),
//        align_en_i (enable hunt/lock), word_rdy_i (consumer ready),
//        word_o/word_vld_o (parallel output), locked_o, ovf_o (dropped word).
module serdes_deser
    import serdes_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(SYNC_WORD_DEFAULT),
    parameter bit               MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ser_i,
    input  logic             ser_vld_i,
    input  logic             align_en_i,
    input  logic             word_rdy_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_vld_o,
    output logic             locked_o,
    output logic             ovf_o
);

    localparam int CNT_W = $clog2(WIDTH);

    deser_state_t     state_q;
    deser_state_t     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_nxt;
    logic             shift_en;
    logic             hit_sync;
    logic             cnt_last;
    logic             word_done;

    // Dropping align_en_i blocks shifting so the cleared state is clean.
    assign shift_en  = ser_vld_i && align_en_i && (state_q != IDLE);
    assign hit_sync  = (sr_nxt == SYNC_WORD);
    assign cnt_last  = (cnt_q == CNT_W'(WIDTH - 1));
    // Completed words equal to the sync word are idle fill.
    assign word_done = shift_en && (state_q == LOCKED) && cnt_last && !hit_sync;

    deser_shift_reg #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_sr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (!align_en_i),
        .en_i  (shift_en),
        .ser_i (ser_i),
        .q_o   (sr_q),
        .nxt_o (sr_nxt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (align_en_i) state_d = HUNT;
            end
            HUNT: begin
                if (shift_en && hit_sync) state_d = LOCKED;
            end
            LOCKED: begin
                state_d = LOCKED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!align_en_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !align_en_i) begin
            cnt_q <= '0;
        end else if (shift_en) begin
            if (state_q == HUNT || cnt_last) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // A pending word survives align_en_i=0; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_o     <= '0;
            word_vld_o <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            ovf_o <= 1'b0;
            if (word_done) begin
                if (word_vld_o && !word_rdy_i) begin
                    ovf_o <= 1'b1;
                end else begin
                    word_o     <= sr_nxt;
                    word_vld_o <= 1'b1;
                end
            end else if (word_vld_o && word_rdy_i) begin
                word_vld_o <= 1'b0;
            end
        end
    end

    assign locked_o = (state_q == LOCKED);

    // sr_q is observed only through nxt_o; keep it referenced.
    logic unused_sr;
    assign unused_sr = ^sr_q;

endmodule
